hazard_stall_controller: RTL and testbench

- Central ID-stage sequencer for the five-stage pipeline.
- Generates PC/IF-ID write enables and IF-ID/ID-EX flush (bubble) controls from three hazard sources:
  - load-use dependences,
  - taken branches/jumps resolved in EX,
  - the multi-cycle multiply/divide unit.
- Owns the mult/div busy counter and a stall-cycle performance counter.
- Sits beside the decode stage, which hosts the register file and immediate sign extension.

---
 rtl/pipeline_ctrl_pkg.sv | 6 +
 rtl/md_busy_timer.sv | 38 +++
 rtl/hazard_stall_controller.sv | 49 ++++
 tb/tb_hazard_stall_controller.sv | 125 ++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared encodings and constants for the pipeline hazard/stall control
package pipeline_ctrl_pkg;
    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
    typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} md_state_t;
endpackage

// File: rtl/md_busy_timer.sv
// md_busy_timer: tracks HI/LO occupancy for MD_CYCLES cycles after each mult/div start
module md_busy_timer
    import pipeline_ctrl_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic ex_md_start,
    output logic md_busy
);
    md_state_t state, state_n;
    logic [5:0] cnt, cnt_n;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (ex_md_start) begin
            state_n = MD_WAIT;
            cnt_n   = 6'(MD_CYCLES - 1);
        end else if (state == MD_WAIT) begin
            state_n = cnt == '0 ? RUN : MD_WAIT;
            cnt_n   = cnt == '0 ? cnt : cnt - 6'd1;
        end
    end
    always_ff @(posedge clk)
        assert (reset || !(state == MD_WAIT && ex_md_start))
            else $error("mult/div restarted while HI/LO busy");
    assign md_busy = state == MD_WAIT;
endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: ID-stage stall/flush sequencing for load-use, branch and mult/div hazards
module hazard_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int MD_CYCLES = 32,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_uses_hilo,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_branch_taken,
    input  logic             ex_md_start,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_count
);
    logic load_use, hilo_haz, stall;
    md_busy_timer #(.MD_CYCLES(MD_CYCLES)) u_timer (
        .clk(clk),
        .reset(reset),
        .ex_md_start(ex_md_start),
        .md_busy(md_busy)
    );
    always_comb begin
        load_use   = ex_mem_read && ex_rt != REG_ZERO &&
                     ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
        hilo_haz   = id_uses_hilo && (md_busy || ex_md_start);
        stall      = !ex_branch_taken && (load_use || hilo_haz);
        pc_write   = !reset && !stall;
        ifid_write = pc_write;
        ifid_flush = reset || ex_branch_taken;
        idex_flush = reset || ex_branch_taken || stall;
    end
    always_ff @(posedge clk) begin
        if (reset)
            stall_count <= '0;
        else if (!pc_write && stall_count != '1)
            stall_count <= stall_count + 1'b1;
    end
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: scoreboard bench for the hazard/stall controller
module tb_hazard_stall_controller;
    localparam int MD = 4;
    localparam int CW = 4;
    logic clk = 0, reset = 1;
    logic [4:0] id_rs = 0, id_rt = 0, ex_rt = 0;
    logic id_uses_rs = 0, id_uses_rt = 0, id_uses_hilo = 0;
    logic ex_mem_read = 0, ex_branch_taken = 0, ex_md_start = 0;
    logic pc_write, ifid_write, ifid_flush, idex_flush, md_busy;
    logic [CW-1:0] stall_count;
    hazard_stall_controller #(.MD_CYCLES(MD), .CNT_W(CW)) dut (
        .clk(clk),
        .reset(reset),
        .id_rs(id_rs),
        .id_rt(id_rt),
        .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt),
        .id_uses_hilo(id_uses_hilo),
        .ex_mem_read(ex_mem_read),
        .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken),
        .ex_md_start(ex_md_start),
        .pc_write(pc_write),
        .ifid_write(ifid_write),
        .ifid_flush(ifid_flush),
        .idex_flush(idex_flush),
        .md_busy(md_busy),
        .stall_count(stall_count)
    );
    always #5 clk = ~clk;
    typedef struct {
        string         tag;
        logic [3:0]    ctrl;
        logic          busy;
        logic [CW-1:0] cnt;
    } exp_t;
    exp_t sb[$];
    int checks = 0, failures = 0;
    int m_left = 0, m_cnt = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, "/ctrl"}, {28'd0, pc_write, ifid_write, ifid_flush, idex_flush}, {28'd0, e.ctrl});
            check({e.tag, "/busy"}, {31'd0, md_busy}, {31'd0, e.busy});
            check({e.tag, "/cnt"}, {28'd0, stall_count}, {28'd0, e.cnt});
        end
    end
    task automatic cyc(input string tag, input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic hilo, input logic mr,
                       input logic [4:0] ert, input logic br, input logic mds);
        logic lu, hz, st, pw;
        exp_t e;
        reset = r; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_uses_hilo = hilo; ex_mem_read = mr; ex_rt = ert; ex_branch_taken = br; ex_md_start = mds;
        lu = mr && ert != 0 && ((urs && rs == ert) || (urt && rt == ert));
        hz = hilo && (m_left > 0 || mds);
        st = !br && (lu || hz);
        pw = !r && !st;
        e.tag  = tag;
        e.ctrl = r ? 4'b0011 : br ? 4'b1111 : st ? 4'b0001 : 4'b1100;
        e.busy = m_left > 0;
        e.cnt  = CW'(m_cnt);
        sb.push_back(e);
        @(posedge clk);
        if (r) begin
            m_left = 0;
            m_cnt  = 0;
        end else begin
            m_left = mds ? MD : (m_left > 0 ? m_left - 1 : 0);
            if (!pw && m_cnt < 2**CW - 1) m_cnt++;
        end
        #1;
    endtask
    task automatic idle(input string tag);
        cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic rst(input string tag);
        cyc(tag, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    initial begin
        @(posedge clk);
        #1;
        rst("rst");
        idle("norm");
        cyc("lu", 0, 8, 0, 1, 0, 0, 1, 8, 0, 0);
        check("lu_cnt", {28'd0, stall_count}, 32'd1);
        idle("lu_next");
        cyc("r0", 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        cyc("unused_rt", 0, 0, 9, 0, 0, 0, 1, 9, 0, 0);
        cyc("lu_rt", 0, 0, 9, 0, 1, 0, 1, 9, 0, 0);
        cyc("br", 0, 8, 0, 1, 0, 0, 1, 8, 1, 0);
        check("br_cnt", {28'd0, stall_count}, 32'd2);
        idle("after_br");
        rst("rst_md");
        cyc("md_start", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        check("md_busy_n1", {31'd0, md_busy}, 32'd1);
        for (int i = 0; i < MD; i++) cyc("md_wait", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        check("md_busy_drop", {31'd0, md_busy}, 32'd0);
        check("md_cnt", {28'd0, stall_count}, 32'd5);
        cyc("md_done", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc("md2_start", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle("md2_w");
        rst("md2_rst");
        check("md2_busy", {31'd0, md_busy}, 32'd0);
        check("md2_cnt", {28'd0, stall_count}, 32'd0);
        idle("md2_post");
        cyc("md3_start", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc("md3_br", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < MD; i++) idle("md3_run");
        rst("rst_sat");
        for (int i = 0; i < 20; i++) cyc("sat", 0, 3, 0, 1, 0, 0, 1, 3, 0, 0);
        check("sat_cnt", {28'd0, stall_count}, 32'd15);
        idle("sat_end");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
